clock_divider_ctrl: RTL and testbench

Programmable clock controller for the Pixy-68000 FPGA. Produces CPUCLK and TIMERCLK from MCLK_IN, as the fixed divider does, but with divide ratios written at run time through a small register port. A CPUCLK ratio change is held pending and applied only at a phase boundary, so CPUCLK never glitches. Adds a periodic timer interrupt with a request/acknowledge handshake; sits between the bus glue logic and the CPU/timer clock nets.

---
 rtl/clock_divider_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_clock_divider_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_ctrl.sv
// rtl/clock_divider_ctrl.sv - run-time programmable CPUCLK/TIMERCLK divider with periodic timer IRQ
//
// Ports:
//   MCLK_IN       master clock (40MHz)
//   RESET_ALL_IN  asynchronous active-high reset
//   REG_WR        single-cycle register write strobe
//   REG_ADDR      register select: 0 CPU_DIV, 1 TMR_DIV, 2 TMR_PERIOD, 3 CTRL
//   REG_WDATA     register write data
//   REG_RDATA     register read data, combinational from REG_ADDR
//   REG_BUSY      CPU divider change pending
//   IRQ_ACK       single-cycle interrupt acknowledge
//   CPUCLK        divided CPU clock (registered)
//   TIMERCLK      divided timer clock (registered)
//   TIMER_IRQ     timer interrupt request, level

`timescale 1ns/1ps

module clock_divider_ctrl #(
    parameter logic [5:0]  CPU_DIV_RST    = 6'd0,
    parameter logic [4:0]  TMR_DIV_RST    = 5'd19,
    parameter logic [15:0] TMR_PERIOD_RST = 16'd1000
) (
    input  logic        MCLK_IN,
    input  logic        RESET_ALL_IN,
    input  logic        REG_WR,
    input  logic [1:0]  REG_ADDR,
    input  logic [15:0] REG_WDATA,
    output logic [15:0] REG_RDATA,
    output logic        REG_BUSY,
    input  logic        IRQ_ACK,
    output logic        CPUCLK,
    output logic        TIMERCLK,
    output logic        TIMER_IRQ
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_ARMED = 1'b1
    } cpu_state_t;

    cpu_state_t  cpu_state;
    cpu_state_t  cpu_state_nxt;

    logic [5:0]  cpu_div_act;
    logic [5:0]  cpu_div_pend;
    logic [5:0]  cpu_cnt;
    logic [4:0]  tmr_div;
    logic [4:0]  tmr_cnt;
    logic [15:0] tmr_period;
    logic [15:0] tick_cnt;
    logic        ctrl_ten;
    logic        ctrl_ien;
    logic        irq_pend;

    logic wr_cpu_div;
    logic wr_tmr_div;
    logic wr_tmr_period;
    logic wr_ctrl;
    logic cpu_toggle;
    logic cpu_fall;
    logic cpu_switch;
    logic tmr_rise;
    logic tick_en;
    logic irq_hit;
    logic irq_clr;

    assign wr_cpu_div    = REG_WR && (REG_ADDR == 2'd0);
    assign wr_tmr_div    = REG_WR && (REG_ADDR == 2'd1);
    assign wr_tmr_period = REG_WR && (REG_ADDR == 2'd2);
    assign wr_ctrl       = REG_WR && (REG_ADDR == 2'd3);

    // A pending ratio is only adopted on a falling toggle, so the high
    // phase in flight always completes at the old length.
    assign cpu_toggle = (cpu_cnt == 6'd0);
    assign cpu_fall   = cpu_toggle && CPUCLK;
    assign cpu_switch = cpu_fall && (cpu_state == ST_ARMED);

    assign tmr_rise = ctrl_ten && (tmr_cnt == 5'd0) && !TIMERCLK;
    assign tick_en  = tmr_rise && (tmr_period != 16'd0);
    assign irq_hit  = tick_en && (tick_cnt == tmr_period - 16'd1);
    assign irq_clr  = IRQ_ACK || (wr_ctrl && REG_WDATA[8]);

    assign REG_BUSY = (cpu_state == ST_ARMED);

    // A write landing on the switch edge re-arms with the new value; the
    // switch itself still consumes the value pending before that write.
    always_comb begin
        cpu_state_nxt = cpu_state;
        case (cpu_state)
            ST_RUN: begin
                if (wr_cpu_div) begin
                    cpu_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (cpu_fall && !wr_cpu_div) begin
                    cpu_state_nxt = ST_RUN;
                end
            end
            default: cpu_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge MCLK_IN or posedge RESET_ALL_IN) begin
        if (RESET_ALL_IN) begin
            cpu_state    <= ST_RUN;
            cpu_div_act  <= CPU_DIV_RST;
            cpu_div_pend <= CPU_DIV_RST;
            cpu_cnt      <= CPU_DIV_RST;
            CPUCLK       <= 1'b0;
        end else begin
            cpu_state <= cpu_state_nxt;
            if (wr_cpu_div) begin
                cpu_div_pend <= REG_WDATA[5:0];
            end
            if (cpu_toggle) begin
                CPUCLK <= ~CPUCLK;
                if (cpu_switch) begin
                    cpu_cnt     <= cpu_div_pend;
                    cpu_div_act <= cpu_div_pend;
                end else begin
                    cpu_cnt <= cpu_div_act;
                end
            end else begin
                cpu_cnt <= cpu_cnt - 6'd1;
            end
        end
    end

    // Holding tmr_cnt at tmr_div while disabled gives a full first
    // half-period once TEN is set again.
    always_ff @(posedge MCLK_IN or posedge RESET_ALL_IN) begin
        if (RESET_ALL_IN) begin
            tmr_cnt  <= TMR_DIV_RST;
            TIMERCLK <= 1'b0;
        end else if (!ctrl_ten) begin
            tmr_cnt  <= tmr_div;
            TIMERCLK <= 1'b0;
        end else if (tmr_cnt == 5'd0) begin
            tmr_cnt  <= tmr_div;
            TIMERCLK <= ~TIMERCLK;
        end else begin
            tmr_cnt <= tmr_cnt - 5'd1;
        end
    end

    // tick_cnt is a plain 16-bit counter: lowering tmr_period below the
    // current count lets it run through 16'hFFFF before matching again.
    always_ff @(posedge MCLK_IN or posedge RESET_ALL_IN) begin
        if (RESET_ALL_IN) begin
            tick_cnt  <= 16'd0;
            irq_pend  <= 1'b0;
            TIMER_IRQ <= 1'b0;
        end else begin
            if (!ctrl_ten) begin
                tick_cnt <= 16'd0;
            end else if (tick_en) begin
                tick_cnt <= irq_hit ? 16'd0 : tick_cnt + 16'd1;
            end
            if (irq_hit) begin
                irq_pend <= 1'b1;
            end else if (irq_clr) begin
                irq_pend <= 1'b0;
            end
            TIMER_IRQ <= irq_pend && ctrl_ien;
        end
    end

    always_ff @(posedge MCLK_IN or posedge RESET_ALL_IN) begin
        if (RESET_ALL_IN) begin
            tmr_div    <= TMR_DIV_RST;
            tmr_period <= TMR_PERIOD_RST;
            ctrl_ten   <= 1'b1;
            ctrl_ien   <= 1'b0;
        end else begin
            if (wr_tmr_div) begin
                tmr_div <= REG_WDATA[4:0];
            end
            if (wr_tmr_period) begin
                tmr_period <= REG_WDATA;
            end
            if (wr_ctrl) begin
                ctrl_ten <= REG_WDATA[0];
                ctrl_ien <= REG_WDATA[1];
            end
        end
    end

    always_comb begin
        REG_RDATA = 16'd0;
        case (REG_ADDR)
            2'd0:    REG_RDATA = {10'd0, cpu_div_act};
            2'd1:    REG_RDATA = {11'd0, tmr_div};
            2'd2:    REG_RDATA = tmr_period;
            default: REG_RDATA = {6'd0, REG_BUSY, irq_pend, 6'd0, ctrl_ien, ctrl_ten};
        endcase
    end

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// tb/tb_clock_divider_ctrl.sv - scoreboard bench for clock_divider_ctrl

`timescale 1ns/1ps

module tb_clock_divider_ctrl;

    localparam int S_CPU  = 0;
    localparam int S_TMR  = 1;
    localparam int S_IRQ  = 2;
    localparam int S_BUSY = 3;
    localparam int S_RD   = 4;

    logic        MCLK_IN;
    logic        RESET_ALL_IN;
    logic        REG_WR;
    logic [1:0]  REG_ADDR;
    logic [15:0] REG_WDATA;
    logic [15:0] REG_RDATA;
    logic        REG_BUSY;
    logic        IRQ_ACK;
    logic        CPUCLK;
    logic        TIMERCLK;
    logic        TIMER_IRQ;

    clock_divider_ctrl dut (
        .MCLK_IN      (MCLK_IN),
        .RESET_ALL_IN (RESET_ALL_IN),
        .REG_WR       (REG_WR),
        .REG_ADDR     (REG_ADDR),
        .REG_WDATA    (REG_WDATA),
        .REG_RDATA    (REG_RDATA),
        .REG_BUSY     (REG_BUSY),
        .IRQ_ACK      (IRQ_ACK),
        .CPUCLK       (CPUCLK),
        .TIMERCLK     (TIMERCLK),
        .TIMER_IRQ    (TIMER_IRQ)
    );

    initial MCLK_IN = 1'b0;
    always #5 MCLK_IN = ~MCLK_IN;

    int cyc = 0;
    always @(posedge MCLK_IN) cyc <= cyc + 1;

    // when >= 0: compare at the falling MCLK edge of that cycle.
    // when <  0: compare immediately when chk_now fires.
    typedef struct {
        int          when;
        int          sig;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    event chk_now;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic push(input int when, input int sig, input logic [15:0] exp, input string name);
        exp_t e;
        e.when = when;
        e.sig  = sig;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    function automatic logic [15:0] sample(input int sig);
        case (sig)
            S_CPU:   return {15'd0, CPUCLK};
            S_TMR:   return {15'd0, TIMERCLK};
            S_IRQ:   return {15'd0, TIMER_IRQ};
            S_BUSY:  return {15'd0, REG_BUSY};
            default: return REG_RDATA;
        endcase
    endfunction

    initial begin : monitor
        logic        at_neg;
        logic [15:0] act;
        int          idx;
        forever begin
            @(negedge MCLK_IN or chk_now);
            at_neg = (MCLK_IN == 1'b0);
            idx = 0;
            while (idx < q.size()) begin
                if ((q[idx].when < 0 && !at_neg) || (at_neg && q[idx].when == cyc)) begin
                    act = sample(q[idx].sig);
                    total_cnt++;
                    if (act === q[idx].exp) begin
                        pass_cnt++;
                    end else begin
                        $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", q[idx].name, act, q[idx].exp, cyc);
                    end
                    q.delete(idx);
                end else if (at_neg && q[idx].when >= 0 && q[idx].when < cyc) begin
                    total_cnt++;
                    $display("FAIL %s: not sampled, expected 0x%0h at cyc %0d", q[idx].name, q[idx].exp, q[idx].when);
                    q.delete(idx);
                end else begin
                    idx++;
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge MCLK_IN);
            #1;
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [15:0] d);
        REG_ADDR  = a;
        REG_WDATA = d;
        REG_WR    = 1'b1;
        step(1);
        REG_WR    = 1'b0;
    endtask

    task automatic ack_pulse();
        IRQ_ACK = 1'b1;
        step(1);
        IRQ_ACK = 1'b0;
    endtask

    initial begin : stimulus
        int r;
        int c;
        int b;
        int e;
        int k;
        int guard;
        logic [15:0] v;

        RESET_ALL_IN = 1'b1;
        REG_WR       = 1'b0;
        REG_ADDR     = 2'd3;
        REG_WDATA    = 16'd0;
        IRQ_ACK      = 1'b0;

        push(1, S_CPU,  16'd0, "rst_cpuclk");
        push(1, S_TMR,  16'd0, "rst_timerclk");
        push(1, S_IRQ,  16'd0, "rst_irq");
        push(1, S_BUSY, 16'd0, "rst_busy");
        push(1, S_RD,   16'h0001, "rst_ctrl");

        #22;
        RESET_ALL_IN = 1'b0;
        r = cyc;

        // Default ratios: CPUCLK toggles every MCLK, TIMERCLK 20 high / 20 low.
        for (int n = 1; n <= 8; n++) push(r + n, S_CPU, 16'(n % 2), $sformatf("dflt_cpuclk_%0d", n));
        push(r + 19, S_TMR, 16'd0, "dflt_tmr_19");
        push(r + 20, S_TMR, 16'd1, "dflt_tmr_20");
        push(r + 39, S_TMR, 16'd1, "dflt_tmr_39");
        push(r + 40, S_TMR, 16'd0, "dflt_tmr_40");
        push(r + 40, S_IRQ, 16'd0, "dflt_irq");
        push(r + 1,  S_RD,  16'h0001, "dflt_ctrl");

        wait_cyc(r + 41);
        REG_ADDR = 2'd0; push(cyc, S_RD, 16'd0,    "dflt_cpu_div");    step(1);
        REG_ADDR = 2'd1; push(cyc, S_RD, 16'd19,   "dflt_tmr_div");    step(1);
        REG_ADDR = 2'd2; push(cyc, S_RD, 16'd1000, "dflt_tmr_period"); step(1);

        // CPU_DIV=3 issued while CPUCLK is high.
        if (((cyc - r) % 2) == 0) step(1);
        c = cyc;
        for (k = c + 1; k <= c + 18; k++) begin
            if (k == c + 1)      v = 16'd0;
            else if (k == c + 2) v = 16'd1;
            else                 v = 16'(((k - c - 3) / 4) % 2);
            push(k, S_CPU, v, $sformatf("div3_cpuclk_%0d", k - c));
        end
        push(c + 1, S_BUSY, 16'd1, "div3_busy_a");
        push(c + 2, S_BUSY, 16'd1, "div3_busy_b");
        push(c + 3, S_BUSY, 16'd0, "div3_busy_clr");
        reg_write(2'd0, 16'd3);
        REG_ADDR = 2'd0;
        push(cyc, S_RD, 16'd0, "div3_rd_old_a"); step(1);
        push(cyc, S_RD, 16'd0, "div3_rd_old_b"); step(1);
        push(cyc, S_RD, 16'd3, "div3_rd_new");
        b = cyc;

        // CPU_DIV=5 then CPU_DIV=1 (upper bits set) before the next fall: last write wins.
        wait_cyc(b + 16);
        for (k = b + 16; k <= b + 35; k++) begin
            if (k < b + 20)      v = 16'd0;
            else if (k < b + 24) v = 16'd1;
            else                 v = 16'(((k - b - 24) / 2) % 2);
            push(k, S_CPU, v, $sformatf("div1_cpuclk_%0d", k - b));
        end
        push(b + 17, S_BUSY, 16'd1, "div1_busy_a");
        push(b + 23, S_BUSY, 16'd1, "div1_busy_b");
        push(b + 24, S_BUSY, 16'd0, "div1_busy_clr");
        reg_write(2'd0, 16'd5);
        reg_write(2'd0, 16'hFFC1);
        REG_ADDR = 2'd0;
        push(cyc, S_RD, 16'd3, "div1_rd_old_a");
        wait_cyc(b + 23);
        push(cyc, S_RD, 16'd3, "div1_rd_old_b"); step(1);
        push(cyc, S_RD, 16'd1, "div1_rd_new");

        // Timer: TMR_DIV=1, TMR_PERIOD=3, then TEN=1 IEN=1.
        reg_write(2'd3, 16'h0000);
        reg_write(2'd1, 16'hFFE1);
        reg_write(2'd2, 16'd3);
        REG_ADDR = 2'd1;
        push(cyc, S_RD, 16'd1, "tmr_div_rd");
        step(1);
        reg_write(2'd3, 16'h0003);
        e = cyc;
        for (k = e; k <= e + 11; k++) begin
            v = (k < e + 2) ? 16'd0 : 16'((((k - e - 2) / 2) % 2) == 0);
            push(k, S_TMR, v, $sformatf("tmr_clk_%0d", k - e));
        end
        push(e + 10, S_IRQ, 16'd0, "irq_pre");
        push(e + 11, S_IRQ, 16'd1, "irq_rise");
        wait_cyc(e + 9);
        REG_ADDR = 2'd3;
        push(cyc, S_RD, 16'h0003, "ctrl_no_pend"); step(1);
        push(cyc, S_RD, 16'h0103, "ctrl_pend");

        wait_cyc(e + 12);
        push(e + 13, S_IRQ, 16'd1, "ack_irq_hold");
        push(e + 14, S_IRQ, 16'd0, "ack_irq_low");
        ack_pulse();

        // Acknowledge coincident with the next set: set wins.
        wait_cyc(e + 21);
        push(e + 22, S_IRQ, 16'd0, "coin_irq_pre");
        push(e + 23, S_IRQ, 16'd1, "coin_irq_rise");
        ack_pulse();
        push(cyc, S_RD, 16'h0103, "coin_pend_kept");
        step(1);

        // CTRL bit8 write clears irq_pend.
        push(e + 24, S_IRQ, 16'd1, "ctrl_clr_hold");
        push(e + 25, S_IRQ, 16'd0, "ctrl_clr_low");
        reg_write(2'd3, 16'h0103);
        push(cyc, S_RD, 16'h0003, "ctrl_clr_rd");

        // Asynchronous reset while ARMED with TIMER_IRQ high.
        wait_cyc(e + 36);
        reg_write(2'd0, 16'd7);
        #1;
        push(-1, S_IRQ,  16'd1, "pre_rst_irq");
        push(-1, S_BUSY, 16'd1, "pre_rst_busy");
        -> chk_now;
        #1;
        RESET_ALL_IN = 1'b1;
        #1;
        push(-1, S_CPU,  16'd0, "async_cpuclk");
        push(-1, S_TMR,  16'd0, "async_timerclk");
        push(-1, S_IRQ,  16'd0, "async_irq");
        push(-1, S_BUSY, 16'd0, "async_busy");
        -> chk_now;
        @(posedge MCLK_IN);
        @(posedge MCLK_IN);
        #2;
        RESET_ALL_IN = 1'b0;
        REG_ADDR = 2'd0; push(cyc, S_RD, 16'd0,      "post_cpu_div");    step(1);
        REG_ADDR = 2'd1; push(cyc, S_RD, 16'd19,     "post_tmr_div");    step(1);
        REG_ADDR = 2'd2; push(cyc, S_RD, 16'd1000,   "post_tmr_period"); step(1);
        REG_ADDR = 2'd3; push(cyc, S_RD, 16'h0001,   "post_ctrl");
        push(cyc, S_IRQ, 16'd0, "post_irq");

        guard = 0;
        while (q.size() > 0 && guard < 100) begin
            step(1);
            guard++;
        end
        step(1);
        foreach (q[i]) $display("FAIL %s: never compared, expected 0x%0h", q[i].name, q[i].exp);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + q.size());
        $finish;
    end

endmodule
